// File: rtl/dc_remover_pkg.sv
// dc_remover shared definitions: sum width, parameter
// legality check and a signed clamp helper.
package dc_remover_pkg;

  // Accumulator width for a window of 2**lg samples of dw bits.
  function automatic int sum_w(input int dw, input int lg);
    return dw + lg;
  endfunction

  function automatic bit params_ok(input int dw, input int lg);
    return (dw >= 8) && (dw <= 32) && (lg >= 1) && (lg <= 8);
  endfunction

  // Clamp a signed value into the range of a w-bit signed word.
  function automatic logic signed [63:0] sat(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/dc_hist_ram.sv
// dc_hist_ram: N-entry circular delay line, register based.
// Ports: clk; flush_i zeroes entries+pointer; wr_en_i writes
// wr_data_i over the oldest entry; rd_data_o = oldest entry
// (read-before-write within the same cycle).
module dc_hist_ram #(
  parameter int DATA_W = 20,
  parameter int N      = 7
) (
  input  logic                     clk,
  input  logic                     flush_i,
  input  logic                     wr_en_i,
  input  logic signed [DATA_W-1:0] wr_data_i,
  output logic signed [DATA_W-1:0] rd_data_o
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N - 1);

  logic signed [DATA_W-1:0] mem_q [N];
  logic [PTR_W-1:0]         ptr_q;
  logic [PTR_W-1:0]         ptr_d;

  // Pointer always addresses the oldest entry, which is also
  // the slot overwritten by the next accepted sample.
  assign rd_data_o = mem_q[ptr_q];

  always_comb begin
    ptr_d = ptr_q;
    if (wr_en_i) begin
      if (ptr_q == PTR_LAST) ptr_d = '0;
      else ptr_d = ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (flush_i) begin
      ptr_q <= '0;
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (wr_en_i) mem_q[ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/dc_remover.sv
// dc_remover: subtracts the running mean of a 2**LOG2_DEPTH
// window from a signed stream, with saturation and bypass.
// Ports: clk, rst (sync, active-high), clear (flush history),
// mode (1 = bypass), in_valid/in_data sample in,
// out_valid/out_data/mean_out result, primed = window full.
module dc_remover
  import dc_remover_pkg::*;
#(
  parameter int DATA_W     = 20,
  parameter int LOG2_DEPTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     mode,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic signed [DATA_W-1:0] mean_out,
  output logic                     primed
);

  localparam int DEPTH  = 1 << LOG2_DEPTH;
  localparam int SUM_W  = sum_w(DATA_W, LOG2_DEPTH);
  localparam int HIST_N = DEPTH - 1;
  localparam logic [LOG2_DEPTH-1:0] FILL_MAX =
    LOG2_DEPTH'(DEPTH - 1);

  if (!params_ok(DATA_W, LOG2_DEPTH)) begin : g_bad_params
    $error("dc_remover: DATA_W or LOG2_DEPTH out of range");
  end

  logic                     accept;
  logic signed [DATA_W-1:0] oldest;
  logic signed [SUM_W-1:0]  x_ext;
  logic signed [SUM_W-1:0]  tot;
  logic signed [DATA_W-1:0] mean_n;
  logic signed [DATA_W:0]   diff;
  logic signed [DATA_W-1:0] diff_sat;

  logic signed [SUM_W-1:0]  sum_q, sum_d;
  logic [LOG2_DEPTH-1:0]    fill_q, fill_d;
  logic                     primed_q, primed_d;
  logic                     vld_q, vld_d;
  logic signed [DATA_W-1:0] data_q, data_d;
  logic signed [DATA_W-1:0] mean_q, mean_d;

  assign accept = in_valid & ~rst & ~clear;

  dc_hist_ram #(
    .DATA_W (DATA_W),
    .N      (HIST_N)
  ) u_hist (
    .clk       (clk),
    .flush_i   (rst | clear),
    .wr_en_i   (accept),
    .wr_data_i (in_data),
    .rd_data_o (oldest)
  );

  // Window sum = stored history plus the current sample.
  // Mean of DATA_W-bit values always fits in DATA_W bits.
  always_comb begin
    x_ext    = SUM_W'(in_data);
    tot      = sum_q + x_ext;
    mean_n   = DATA_W'(tot >>> LOG2_DEPTH);
    diff     = (DATA_W+1)'(in_data) - (DATA_W+1)'(mean_n);
    diff_sat = DATA_W'(sat(64'(diff), DATA_W));
  end

  always_comb begin
    sum_d    = sum_q;
    fill_d   = fill_q;
    primed_d = primed_q;
    vld_d    = 1'b0;
    data_d   = data_q;
    mean_d   = mean_q;
    if (clear) begin
      sum_d    = '0;
      fill_d   = '0;
      primed_d = 1'b0;
    end else if (in_valid) begin
      sum_d    = tot - SUM_W'(oldest);
      vld_d    = 1'b1;
      data_d   = mode ? in_data : diff_sat;
      mean_d   = mean_n;
      // Previous count at max means this is sample DEPTH.
      if (fill_q == FILL_MAX) primed_d = 1'b1;
      else fill_d = fill_q + LOG2_DEPTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q    <= '0;
      fill_q   <= '0;
      primed_q <= 1'b0;
      vld_q    <= 1'b0;
      data_q   <= '0;
      mean_q   <= '0;
    end else begin
      sum_q    <= sum_d;
      fill_q   <= fill_d;
      primed_q <= primed_d;
      vld_q    <= vld_d;
      data_q   <= data_d;
      mean_q   <= mean_d;
    end
  end

  assign out_valid = vld_q;
  assign out_data  = data_q;
  assign mean_out  = mean_q;
  assign primed    = primed_q;

endmodule

// File: tb/tb_dc_remover.sv
// tb_dc_remover: directed vectors with a scoreboard queue;
// a negedge monitor pops and checks each output strobe.
module tb_dc_remover;

  localparam int DW = 20;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 clear = 1'b0;
  logic                 mode = 1'b0;
  logic                 in_valid = 1'b0;
  logic signed [DW-1:0] in_data = '0;
  logic                 out_valid;
  logic signed [DW-1:0] out_data;
  logic signed [DW-1:0] mean_out;
  logic                 primed;

  typedef struct {
    int  d;
    int  m;
    bit  p;
    time t;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  dc_remover #(
    .DATA_W     (DW),
    .LOG2_DEPTH (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .mean_out  (mean_out),
    .primed    (primed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got 1 expected 0 at %0t",
                 $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_data", out_data, e.d);
        chk("mean_out", mean_out, e.m);
        chk("primed", primed, e.p);
        chk("latency", $time, e.t + 5);
      end
    end
  end

  task automatic send(input int x, input bit m, input int ed,
                      input int em, input bit ep);
    in_valid = 1'b1;
    in_data  = DW'(x);
    mode     = m;
    @(posedge clk);
    q.push_back('{ed, em, ep, $time});
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_zero(input string tag);
    @(negedge clk);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_mean"}, mean_out, 0);
    chk({tag, "_primed"}, primed, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_zero("reset");
    #1;
  endtask

  task automatic step_test(input bit gapped);
    for (int k = 1; k <= 12; k++) begin
      int m;
      m = 100 * ((k < 8) ? k : 8);
      send(800, 1'b0, 800 - m, m, k >= 8);
      if (gapped) idle($urandom_range(0, 3));
    end
    idle(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle(1);
    do_reset();

    step_test(1'b0);

    do_reset();
    send(-1, 1'b0, 0, -1, 1'b0);
    send(1, 1'b0, 1, 0, 1'b0);
    idle(2);

    do_reset();
    for (int k = 1; k <= 7; k++)
      send(-524288, 1'b0, -524288 + 65536 * k, -65536 * k, 1'b0);
    send(524287, 1'b0, 524287, -393217, 1'b1);
    idle(2);

    do_reset();
    for (int k = 1; k <= 7; k++) begin
      int m;
      m = (524287 * k) / 8;
      send(524287, 1'b0, 524287 - m, m, 1'b0);
    end
    send(-524288, 1'b0, -524288, 393215, 1'b1);
    idle(2);

    do_reset();
    for (int k = 1; k <= 8; k++)
      send(1234, 1'b1, 1234, (1234 * k) / 8, k == 8);
    send(1234, 1'b0, 0, 1234, 1'b1);
    idle(2);

    do_reset();
    step_test(1'b1);

    do_reset();
    for (int k = 1; k <= 5; k++)
      send(800, 1'b0, 800 - 100 * k, 100 * k, 1'b0);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = DW'(800);
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("clear_valid", out_valid, 0);
    chk("clear_primed", primed, 0);
    chk("clear_hold_data", out_data, 300);
    chk("clear_hold_mean", mean_out, 500);
    #1;
    send(800, 1'b0, 700, 100, 1'b0);
    send(800, 1'b0, 600, 200, 1'b0);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = DW'(800);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    chk_zero("midrst");
    idle(3);

    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
